// File: rtl/mdc_pkg.sv
// Shared types and helpers for the multi-digit down counter.
// Digits are 4-bit nibbles packed LSD-first into a flat vector.
package mdc_pkg;

   localparam int DIGIT_W    = 4;
   localparam int MAX_DIGITS = 8;
   localparam int EXT_W      = MAX_DIGITS * DIGIT_W;

   typedef logic [DIGIT_W-1:0] digit_t;

   function automatic digit_t get_digit(
      input logic [EXT_W-1:0] vec,
      input int unsigned      idx
   );
      return vec[idx*DIGIT_W +: DIGIT_W];
   endfunction

   function automatic digit_t clamp_digit(
      input digit_t d,
      input digit_t max
   );
      return (d > max) ? max : d;
   endfunction

endpackage

// File: rtl/mdc_digit.sv
// One down-counting digit: reset, load, borrow-gated step, reload on borrow.
// Exposes a zero flag used to build the borrow chain.
module mdc_digit
   import mdc_pkg::*;
#(
   parameter int DIGIT_MAX = 9
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   i_load,
   input  digit_t i_load_val,
   input  logic   i_step,
   output digit_t o_value,
   output logic   o_zero
);

   localparam digit_t MAX_D = digit_t'(DIGIT_MAX);

   digit_t r_value;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_value <= '0;
      end else if (i_load) begin
         r_value <= i_load_val;
      end else if (i_step) begin
         r_value <= (r_value == '0) ? MAX_D : r_value - 1'b1;
      end
   end

   assign o_value = r_value;
   assign o_zero  = (r_value == '0);

endmodule

// File: rtl/multi_digit_down_counter.sv
// Cascaded down counter with borrow chain, terminal counts and expiry pulse.
// Optional MDC_LOAD_CLAMP_EN clamps loaded digits above DIGIT_MAX.
module multi_digit_down_counter
   import mdc_pkg::*;
#(
   parameter int DIGITS    = 3,
   parameter int DIGIT_MAX = 9,
   parameter int WRAP      = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      loadN,
   input  logic                      ena,
   input  logic                      ena_cnt,
   input  logic [DIGIT_W*DIGITS-1:0] datain,
   output logic [DIGIT_W*DIGITS-1:0] count,
   output logic [DIGITS-1:0]         digit_tc,
   output logic                      tc,
   output logic                      expired
);

   localparam int            CW    = DIGIT_W * DIGITS;
   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam digit_t        MAX_D = digit_t'(DIGIT_MAX);

   logic             w_load;
   logic             w_step;
   logic             w_expire_next;
   logic [EXT_W-1:0] w_din_ext;
   logic [DIGITS-1:0] w_zero;
   logic [DIGITS-1:0] w_borrow;
   logic             r_expired;

   assign w_load    = ~loadN;
   assign w_din_ext = EXT_W'(datain);

   // Hold mode freezes the step once everything has reached zero.
   assign w_step = ena && ena_cnt && !w_load && ((WRAP != 0) || !tc);

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_digit
         digit_t w_raw;
         digit_t w_load_val;
         digit_t w_value;

         assign w_raw = get_digit(w_din_ext, g);
`ifdef MDC_LOAD_CLAMP_EN
         assign w_load_val = clamp_digit(w_raw, MAX_D);
`else
         assign w_load_val = w_raw;
`endif

         if (g == 0) begin : g_lsd
            assign w_borrow[g] = 1'b1;
         end else begin : g_upper
            assign w_borrow[g] = w_borrow[g-1] & w_zero[g-1];
         end

         mdc_digit #(
            .DIGIT_MAX (DIGIT_MAX)
         ) u_digit (
            .clk        (clk),
            .reset      (reset),
            .i_load     (w_load),
            .i_load_val (w_load_val),
            .i_step     (w_step & w_borrow[g]),
            .o_value    (w_value),
            .o_zero     (w_zero[g])
         );

         assign count[g*DIGIT_W +: DIGIT_W] = w_value;
      end
   endgenerate

   assign digit_tc = w_zero;
   assign tc       = &w_zero;

   // A step lands on all-zero from nonzero only when the count is exactly one.
   assign w_expire_next = w_step && (count == ONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_expired <= 1'b0;
      end else begin
         r_expired <= w_expire_next;
      end
   end

   assign expired = r_expired;

endmodule

// File: tb/tb_multi_digit_down_counter.sv
// Scoreboard bench: wrap and hold instances share stimulus; a digit-array
// reference model predicts each edge, a negedge monitor compares.
module tb_multi_digit_down_counter;

   localparam int D  = 3;
   localparam int MX = 9;

   logic        clk = 1'b0;
   logic        reset, loadN, ena, ena_cnt;
   logic [11:0] datain;
   logic [11:0] cnt_w, cnt_h;
   logic [2:0]  dtc_w, dtc_h;
   logic        tc_w, tc_h, ex_w, ex_h;

   always #5 clk = ~clk;

   multi_digit_down_counter #(.DIGITS(D), .DIGIT_MAX(MX), .WRAP(1)) u_wrap (
      .clk(clk), .reset(reset), .loadN(loadN), .ena(ena),
      .ena_cnt(ena_cnt), .datain(datain), .count(cnt_w),
      .digit_tc(dtc_w), .tc(tc_w), .expired(ex_w)
   );

   multi_digit_down_counter #(.DIGITS(D), .DIGIT_MAX(MX), .WRAP(0)) u_hold (
      .clk(clk), .reset(reset), .loadN(loadN), .ena(ena),
      .ena_cnt(ena_cnt), .datain(datain), .count(cnt_h),
      .digit_tc(dtc_h), .tc(tc_h), .expired(ex_h)
   );

   typedef struct {
      logic [11:0] cnt;
      logic        ex;
   } exp_t;

   exp_t q_w[$];
   exp_t q_h[$];
   int   m[2][D];
   bit   mex[2];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic check_dut(string tag, exp_t e, logic [11:0] c,
                            logic [2:0] dt, logic t, logic x);
      logic [2:0] edt;
      for (int i = 0; i < D; i++) edt[i] = (e.cnt[4*i +: 4] == 4'h0);
      check({tag, "_count"}, c, e.cnt);
      check({tag, "_expired"}, x, e.ex);
      check({tag, "_tc"}, t, (e.cnt == 12'h000));
      check({tag, "_digit_tc"}, dt, edt);
   endtask

   function automatic logic [11:0] pack(int k);
      logic [11:0] v = '0;
      for (int i = 0; i < D; i++) v[4*i +: 4] = 4'(m[k][i]);
      return v;
   endfunction

   // Reference: digit i steps when all lower digits read zero before the edge.
   task automatic model_edge(bit rst, bit ld_n, bit en, bit ec, logic [11:0] din);
      for (int k = 0; k < 2; k++) begin
         bit wrap = (k == 0);
         if (rst) begin
            for (int i = 0; i < D; i++) m[k][i] = 0;
            mex[k] = 0;
         end else if (!ld_n) begin
            for (int i = 0; i < D; i++) begin
               int v = int'(din[4*i +: 4]);
`ifdef MDC_LOAD_CLAMP_EN
               if (v > MX) v = MX;
`endif
               m[k][i] = v;
            end
            mex[k] = 0;
         end else if (en && ec) begin
            bit nz = 0;
            for (int i = 0; i < D; i++) if (m[k][i] != 0) nz = 1;
            if (!nz && !wrap) begin
               mex[k] = 0;
            end else begin
               bit lowz = 1;
               bit allz = 1;
               for (int i = 0; i < D; i++) begin
                  int old = m[k][i];
                  if (lowz) m[k][i] = (old == 0) ? MX : old - 1;
                  lowz = lowz && (old == 0);
               end
               for (int i = 0; i < D; i++) if (m[k][i] != 0) allz = 0;
               mex[k] = nz && allz;
            end
         end else begin
            mex[k] = 0;
         end
      end
   endtask

   task automatic cyc(bit rst, bit ld_n, bit en, bit ec, logic [11:0] din);
      @(negedge clk);
      reset   = rst;
      loadN   = ld_n;
      ena     = en;
      ena_cnt = ec;
      datain  = din;
      @(posedge clk);
      model_edge(rst, ld_n, en, ec, din);
      q_w.push_back('{pack(0), mex[0]});
      q_h.push_back('{pack(1), mex[1]});
   endtask

   always @(negedge clk) begin
      if (q_w.size() > 0) check_dut("wrap", q_w.pop_front(), cnt_w, dtc_w, tc_w, ex_w);
      if (q_h.size() > 0) check_dut("hold", q_h.pop_front(), cnt_h, dtc_h, tc_h, ex_h);
   end

   initial begin
      reset = 1'b1; loadN = 1'b1; ena = 1'b0; ena_cnt = 1'b0; datain = '0;
      cyc(1, 1, 0, 0, 12'h000);
      cyc(1, 1, 0, 0, 12'h000);
      // load 100, single step
      cyc(0, 0, 0, 0, 12'h100);
      cyc(0, 1, 1, 1, 12'h000);
      // step from zero: wrap vs hold
      cyc(1, 1, 0, 0, 12'h000);
      cyc(0, 1, 1, 1, 12'h000);
      cyc(0, 1, 1, 1, 12'h000);
      // expiry and hold-at-zero, then resume
      cyc(0, 0, 0, 0, 12'h001);
      cyc(0, 1, 1, 1, 12'h000);
      repeat (3) cyc(0, 1, 1, 1, 12'h000);
      cyc(0, 0, 0, 0, 12'h005);
      cyc(0, 1, 1, 1, 12'h000);
      // load beats step; ena low freezes
      cyc(0, 0, 1, 1, 12'h250);
      repeat (10) cyc(0, 1, 0, 1, 12'h000);
      // reset beats load and step; load zero never expires
      cyc(0, 0, 0, 0, 12'h437);
      cyc(1, 0, 1, 1, 12'h437);
      cyc(0, 0, 1, 1, 12'h000);
      repeat (2) cyc(0, 1, 1, 1, 12'h000);
      // out-of-range digit
      cyc(0, 0, 0, 0, 12'h00C);
      cyc(0, 1, 1, 1, 12'h000);
      cyc(0, 1, 1, 1, 12'h000);
      repeat (3000) begin
         logic [11:0] din;
         int mode = $urandom_range(0, 3);
         case (mode)
            0: din = 12'($urandom_range(0, 3));
            1: din = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9))};
            2: din = 12'($urandom);
            default: din = {4'h0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         endcase
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 15) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, din);
      end
      @(negedge clk);
      #1;
      check("queue_drain", q_w.size() + q_h.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
